// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - Shared Ethernet/IPv4/UDP transmit constants, FSM states and nibble CRC step.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE, CHECK_SUM, PREAMBLE, ETH_HEAD, IP_UDP_HEAD, SEND_DATA, SEND_CRC
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
  localparam logic [7:0]  IP_TTL        = 8'h40;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [15:0] MAX_PAYLOAD   = 16'd1472;
  localparam logic [15:0] MIN_PAYLOAD   = 16'd18;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  // 04C11DB7h bit-reversed, so bits are consumed LSB first as they leave the wire
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  function automatic logic [31:0] crc32_nibble(input logic [31:0] crc, input logic [3:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d4.sv
// rtl/crc32_d4.sv - Reflected Ethernet CRC-32 register advancing one nibble per enabled cycle.
module crc32_d4
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [3:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) crc <= CRC_INIT;
    else if (en)       crc <= crc32_nibble(crc, data);
  end

endmodule

// File: rtl/udp_ip_send.sv
// rtl/udp_ip_send.sv - UDP/IPv4/Ethernet frame transmitter onto a 4-bit PHY nibble stream.
// Define UDP_TX_PAD_EN to zero-pad short payloads up to the 46-byte Ethernet minimum.
module udp_ip_send
  import eth_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC  = 48'h12_34_56_78_9A_BC,
  parameter logic [31:0] BOARD_IP   = {8'd169, 8'd254, 8'd1, 8'd23},
  parameter logic [15:0] BOARD_PORT = 16'd1234,
  parameter logic [47:0] DES_MAC    = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] DES_IP     = {8'd169, 8'd254, 8'd191, 8'd31},
  parameter logic [15:0] DES_PORT   = 16'd1234
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        send_en,
  input  logic [15:0] send_data_num,
  input  logic [31:0] send_data,
  output logic        send_data_req,
  output logic        eth_tx_en,
  output logic [3:0]  eth_tx_data,
  output logic        send_end,
  output logic        busy
);

  state_t       state;
  logic [11:0]  cnt;
  logic [15:0]  num;
  logic [15:0]  ident;
  logic [19:0]  sum;
  logic [15:0]  csum;
  logic [31:0]  word;
  logic [31:0]  crc;
  logic         accept;
  logic         crc_en;
  logic         req_next;
  logic [3:0]   nib;
  logic [15:0]  ip_len;
  logic [15:0]  udp_len;
  logic [11:0]  num_nibs;
  logic [11:0]  data_nibs;
  logic [335:0] hdr;
  logic [335:0] hdr_sh;
  logic [31:0]  pl_src;
  logic [31:0]  pl_sh;
  logic [31:0]  crc_sh;

  // send_end still high means the frame just closed; that cycle's send_en is dropped
  assign accept   = (state == IDLE) && send_en && !send_end;
  assign ip_len   = num + 16'd28;
  assign udp_len  = num + 16'd8;
  assign num_nibs = {num[10:0], 1'b0};
`ifdef UDP_TX_PAD_EN
  assign data_nibs = (num < MIN_PAYLOAD) ? {MIN_PAYLOAD[10:0], 1'b0} : num_nibs;
`else
  assign data_nibs = num_nibs;
`endif

  assign hdr = {DES_MAC, BOARD_MAC, ETH_TYPE_IP, 8'h45, 8'h00, ip_len, ident, 16'h4000,
                IP_TTL, IP_PROTO_UDP, csum, BOARD_IP, DES_IP, BOARD_PORT, DES_PORT,
                udp_len, 16'h0000};
  assign hdr_sh = hdr << {cnt[11:1], 3'b000};
  // The first nibble of each word comes straight off send_data, the rest from the latch
  assign pl_src = (cnt[2:0] == 3'd0) ? send_data : word;
  assign pl_sh  = pl_src << {cnt[2:1], 3'b000};
  assign crc_sh = crc >> {cnt[2:0], 2'b00};
  assign crc_en = (state == ETH_HEAD) || (state == IP_UDP_HEAD) || (state == SEND_DATA);

  assign req_next = ((state == IP_UDP_HEAD) && (cnt == 12'd82) && (num_nibs != 12'd0)) ||
                    ((state == SEND_DATA) && (cnt[2:0] == 3'd6) && ((cnt + 12'd2) < num_nibs));

  always_comb begin
    nib = 4'h0;
    case (state)
      PREAMBLE: begin
        if (cnt[3:0] == 4'd15)      nib = SFD_BYTE[7:4];
        else if (cnt[3:0] == 4'd14) nib = SFD_BYTE[3:0];
        else                        nib = cnt[0] ? PREAMBLE_BYTE[7:4] : PREAMBLE_BYTE[3:0];
      end
      ETH_HEAD, IP_UDP_HEAD: nib = cnt[0] ? hdr_sh[335:332] : hdr_sh[331:328];
      SEND_DATA: if (cnt < num_nibs) nib = cnt[0] ? pl_sh[31:28] : pl_sh[27:24];
      SEND_CRC:  nib = ~crc_sh[3:0];
      default:   nib = 4'h0;
    endcase
  end

  crc32_d4 u_crc (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .clr   (accept),
    .en    (crc_en),
    .data  (nib),
    .crc   (crc)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      num           <= '0;
      ident         <= '0;
      sum           <= '0;
      csum          <= '0;
      word          <= '0;
      send_data_req <= 1'b0;
      eth_tx_en     <= 1'b0;
      eth_tx_data   <= 4'h0;
      send_end      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      send_data_req <= req_next;
      send_end      <= 1'b0;
      case (state)
        IDLE: begin
          eth_tx_en   <= 1'b0;
          eth_tx_data <= 4'h0;
          busy        <= accept;
          if (accept) begin
            num   <= (send_data_num > MAX_PAYLOAD) ? MAX_PAYLOAD : send_data_num;
            cnt   <= '0;
            state <= CHECK_SUM;
          end
        end
        CHECK_SUM: begin
          cnt <= cnt + 12'd1;
          if (cnt[1:0] == 2'd0) begin
            sum <= 20'(16'h4500) + 20'(ip_len) + 20'(ident) + 20'(16'h4000) +
                   20'({IP_TTL, IP_PROTO_UDP}) + 20'(BOARD_IP[31:16]) + 20'(BOARD_IP[15:0]) +
                   20'(DES_IP[31:16]) + 20'(DES_IP[15:0]);
          end else if (cnt[1:0] == 2'd1) begin
            sum <= {4'd0, sum[15:0]} + {16'd0, sum[19:16]};
          end else begin
            csum  <= ~(sum[15:0] + {12'd0, sum[19:16]});
            cnt   <= '0;
            state <= PREAMBLE;
          end
        end
        PREAMBLE: begin
          eth_tx_en   <= 1'b1;
          eth_tx_data <= nib;
          cnt         <= (cnt == 12'd15) ? 12'd0 : cnt + 12'd1;
          if (cnt == 12'd15) state <= ETH_HEAD;
        end
        ETH_HEAD: begin
          eth_tx_data <= nib;
          cnt         <= cnt + 12'd1;
          if (cnt == 12'd27) state <= IP_UDP_HEAD;
        end
        IP_UDP_HEAD: begin
          eth_tx_data <= nib;
          if (cnt == 12'd83) begin
            cnt   <= '0;
            state <= (data_nibs == 12'd0) ? SEND_CRC : SEND_DATA;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        SEND_DATA: begin
          eth_tx_data <= nib;
          if (cnt[2:0] == 3'd0) word <= send_data;
          if (cnt == data_nibs - 12'd1) begin
            cnt   <= '0;
            state <= SEND_CRC;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        SEND_CRC: begin
          if (cnt == 12'd8) begin
            eth_tx_en   <= 1'b0;
            eth_tx_data <= 4'h0;
            send_end    <= 1'b1;
            ident       <= ident + 16'd1;
            cnt         <= '0;
            state       <= IDLE;
          end else begin
            eth_tx_data <= nib;
            cnt         <= cnt + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_ip_send.sv
// tb/tb_udp_ip_send.sv - Directed self-checking bench for udp_ip_send.
module tb_udp_ip_send;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        send_en = 1'b0;
  logic [15:0] send_data_num = '0;
  logic [31:0] send_data = '0;
  logic        send_data_req;
  logic        eth_tx_en;
  logic [3:0]  eth_tx_data;
  logic        send_end;
  logic        busy;

  int checks = 0;
  int passes = 0;
  logic [3:0]  cap[$];
  logic [7:0]  exp_b[$];
  logic [31:0] exp_crc;
  logic [15:0] exp_id = '0;
  int req_cnt, first_en, end_cnt, idle_bad;
  logic busy_at1, busy_at_end, busy_after;

`ifdef UDP_TX_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  udp_ip_send dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .send_en       (send_en),
    .send_data_num (send_data_num),
    .send_data     (send_data),
    .send_data_req (send_data_req),
    .eth_tx_en     (eth_tx_en),
    .eth_tx_data   (eth_tx_data),
    .send_end      (send_end),
    .busy          (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference frame: preamble, headers, payload(+pad), CRC, all as bytes.
  task automatic build_expected(input int n, input logic [15:0] id, input logic [31:0] base);
    logic [15:0] hw [21];
    logic [31:0] s, c, w;
    int plen;
    exp_b.delete();
    for (int i = 0; i < 7; i++) exp_b.push_back(8'h55);
    exp_b.push_back(8'hD5);
    hw = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1234, 16'h5678, 16'h9ABC, 16'h0800, 16'h4500,
           16'(n + 28), id, 16'h4000, 16'h4011, 16'h0000, 16'hA9FE, 16'h0117, 16'hA9FE,
           16'hBF1F, 16'd1234, 16'd1234, 16'(n + 8), 16'h0000};
    s = 0;
    for (int i = 7; i < 17; i++) s += {16'd0, hw[i]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    hw[12] = ~s[15:0];
    for (int i = 0; i < 21; i++) begin
      exp_b.push_back(hw[i][15:8]);
      exp_b.push_back(hw[i][7:0]);
    end
    plen = (PAD && n < 18) ? 18 : n;
    for (int i = 0; i < plen; i++) begin
      w = base + 32'(i / 4) * 32'h0404_0404;
      exp_b.push_back((i < n) ? w[31 - 8 * (i % 4) -: 8] : 8'h00);
    end
    c = 32'hFFFF_FFFF;
    for (int j = 8; j < exp_b.size(); j++) begin
      c ^= {24'd0, exp_b[j]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    exp_crc = ~c;
    for (int k = 0; k < 4; k++) exp_b.push_back(exp_crc[8 * k +: 8]);
  endtask

  function automatic int first_diff();
    if (cap.size() != 2 * exp_b.size()) return -2;
    for (int j = 0; j < exp_b.size(); j++)
      if ({cap[2 * j + 1], cap[2 * j]} !== exp_b[j]) return j;
    return -1;
  endfunction

  function automatic logic [15:0] field16(input int j);
    if (cap.size() < 2 * j + 4) return 16'hxxxx;
    return {cap[2 * j + 1], cap[2 * j], cap[2 * j + 3], cap[2 * j + 2]};
  endfunction

  function automatic logic [31:0] got_crc();
    logic [31:0] g;
    int s;
    s = cap.size();
    if (s < 8) return 32'hxxxx_xxxx;
    for (int k = 0; k < 8; k++) g[4 * k +: 4] = cap[s - 8 + k];
    return g;
  endfunction

  // Starts one frame, feeds words one cycle after each request, records the nibble stream.
  task automatic run_frame(input logic [15:0] n, input logic [31:0] base, input int spur,
                           input bit end_pulse);
    bit prev_req = 1'b0;
    int widx = 0;
    cap.delete();
    req_cnt = 0; first_en = -1; end_cnt = 0; idle_bad = 0;
    busy_at1 = 1'b0; busy_at_end = 1'b0;
    @(negedge sys_clk);
    send_en = 1'b1;
    send_data_num = n;
    for (int cyc = 1; cyc < 4000; cyc++) begin
      @(negedge sys_clk);
      send_en = (cyc == spur);
      send_data = prev_req ? base + 32'(widx) * 32'h0404_0404 : 32'hA5A5_A5A5;
      if (prev_req) widx++;
      prev_req = send_data_req;
      if (cyc == 1) busy_at1 = busy;
      if (send_data_req) req_cnt++;
      if (eth_tx_en) begin
        if (first_en < 0) first_en = cyc;
        cap.push_back(eth_tx_data);
      end else if (eth_tx_data !== 4'h0) begin
        idle_bad++;
      end
      if (send_end) begin
        end_cnt++;
        busy_at_end = busy;
        if (end_pulse) send_en = 1'b1;
        break;
      end
    end
    @(negedge sys_clk);
    send_en = 1'b0;
    busy_after = busy;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++; if (eth_tx_en !== 1'b0) $display("FAIL reset_tx_en: got %b expected 0", eth_tx_en); else passes++;
    checks++; if (eth_tx_data !== 4'h0) $display("FAIL reset_tx_data: got %h expected 0", eth_tx_data); else passes++;
    checks++; if (send_data_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", send_data_req); else passes++;
    checks++; if (send_end !== 1'b0) $display("FAIL reset_send_end: got %b expected 0", send_end); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
    sys_rst_n = 1'b1;
    exp_id = 16'h0000;
    @(negedge sys_clk);
  endtask

  task automatic test_n4();
    int d;
    run_frame(16'd4, 32'h3132_3334, -1, 1'b0);
    build_expected(4, exp_id, 32'h3132_3334);
    d = first_diff();
    checks++; if (first_en !== 5) $display("FAIL n4_first_nibble_latency: got %0d expected 5", first_en); else passes++;
    checks++; if (cap.size() !== (PAD ? 144 : 116)) $display("FAIL n4_nibble_count: got %0d expected %0d", cap.size(), PAD ? 144 : 116); else passes++;
    checks++; if (req_cnt !== 1) $display("FAIL n4_req_pulses: got %0d expected 1", req_cnt); else passes++;
    checks++; if (field16(24) !== 16'h0020) $display("FAIL n4_ip_length: got %h expected 0020", field16(24)); else passes++;
    checks++; if (field16(46) !== 16'h000C) $display("FAIL n4_udp_length: got %h expected 000c", field16(46)); else passes++;
    checks++; if (field16(26) !== exp_id) $display("FAIL n4_ident: got %h expected %h", field16(26), exp_id); else passes++;
    checks++; if (got_crc() !== exp_crc) $display("FAIL n4_crc: got %h expected %h", got_crc(), exp_crc); else passes++;
    checks++; if (d !== -1) $display("FAIL n4_frame_bytes: first bad byte %0d expected none", d); else passes++;
    checks++; if (idle_bad !== 0) $display("FAIL n4_idle_data_zero: got %0d nonzero expected 0", idle_bad); else passes++;
    checks++; if (busy_at1 !== 1'b1) $display("FAIL n4_busy_after_accept: got %b expected 1", busy_at1); else passes++;
    checks++; if (end_cnt !== 1 || busy_at_end !== 1'b1) $display("FAIL n4_send_end: got end=%0d busy=%b expected end=1 busy=1", end_cnt, busy_at_end); else passes++;
    checks++; if (busy_after !== 1'b0) $display("FAIL n4_busy_cleared: got %b expected 0", busy_after); else passes++;
    exp_id++;
  endtask

  task automatic test_n6();
    int d;
    run_frame(16'd6, 32'h3132_3334, -1, 1'b0);
    build_expected(6, exp_id, 32'h3132_3334);
    d = first_diff();
    checks++; if (req_cnt !== 2) $display("FAIL n6_req_pulses: got %0d expected 2", req_cnt); else passes++;
    checks++; if (field16(24) !== 16'h0022) $display("FAIL n6_ip_length: got %h expected 0022", field16(24)); else passes++;
    checks++; if (field16(54) !== (PAD ? 16'h3536 : 16'h3536)) $display("FAIL n6_tail_bytes: got %h expected 3536", field16(54)); else passes++;
    checks++; if (d !== -1) $display("FAIL n6_frame_bytes: first bad byte %0d expected none", d); else passes++;
    exp_id++;
  endtask

  task automatic test_zero();
    int d;
    run_frame(16'd0, 32'h0BAD_F00D, -1, 1'b0);
    build_expected(0, exp_id, 32'h0BAD_F00D);
    d = first_diff();
    checks++; if (req_cnt !== 0) $display("FAIL n0_req_pulses: got %0d expected 0", req_cnt); else passes++;
    checks++; if (cap.size() !== (PAD ? 144 : 108)) $display("FAIL n0_nibble_count: got %0d expected %0d", cap.size(), PAD ? 144 : 108); else passes++;
    checks++; if (d !== -1) $display("FAIL n0_frame_bytes: first bad byte %0d expected none", d); else passes++;
    exp_id++;
  endtask

  task automatic test_clamp();
    int d;
    run_frame(16'd2000, 32'h0001_0203, -1, 1'b0);
    build_expected(1472, exp_id, 32'h0001_0203);
    d = first_diff();
    checks++; if (req_cnt !== 368) $display("FAIL clamp_req_pulses: got %0d expected 368", req_cnt); else passes++;
    checks++; if (field16(24) !== 16'h05DC) $display("FAIL clamp_ip_length: got %h expected 05dc", field16(24)); else passes++;
    checks++; if (cap.size() !== 3052) $display("FAIL clamp_nibble_count: got %0d expected 3052", cap.size()); else passes++;
    checks++; if (d !== -1) $display("FAIL clamp_frame_bytes: first bad byte %0d expected none", d); else passes++;
    exp_id++;
  endtask

  task automatic test_back_to_back();
    int d;
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    exp_id = 16'h0000;
    run_frame(16'd4, 32'h4142_4344, 40, 1'b0);
    build_expected(4, 16'h0000, 32'h4142_4344);
    d = first_diff();
    checks++; if (field16(26) !== 16'h0000) $display("FAIL b2b_ident_first: got %h expected 0000", field16(26)); else passes++;
    checks++; if (d !== -1 || end_cnt !== 1) $display("FAIL b2b_first_frame: bad byte %0d ends %0d expected none/1", d, end_cnt); else passes++;
    checks++; if (busy_after !== 1'b0) $display("FAIL b2b_busy_after_first: got %b expected 0", busy_after); else passes++;
    run_frame(16'd4, 32'h5152_5354, -1, 1'b1);
    build_expected(4, 16'h0001, 32'h5152_5354);
    d = first_diff();
    checks++; if (field16(26) !== 16'h0001) $display("FAIL b2b_ident_second: got %h expected 0001", field16(26)); else passes++;
    checks++; if (d !== -1) $display("FAIL b2b_second_frame: first bad byte %0d expected none", d); else passes++;
    checks++; if (busy_after !== 1'b0) $display("FAIL b2b_send_en_at_end_ignored: busy %b expected 0", busy_after); else passes++;
    exp_id = 16'h0002;
  endtask

  task automatic test_reset_mid();
    int n_nib = 0;
    bit hit = 1'b0;
    bit seen = 1'b0;
    int d;
    @(negedge sys_clk);
    send_en = 1'b1;
    send_data_num = 16'd10;
    for (int cyc = 1; cyc < 500 && !hit; cyc++) begin
      @(negedge sys_clk);
      send_en = 1'b0;
      if (eth_tx_en) n_nib++;
      if (n_nib == 60) begin
        sys_rst_n = 1'b0;
        hit = 1'b1;
      end
    end
    checks++; if (hit !== 1'b1) $display("FAIL rst_mid_reached_nibble60: got %0d nibbles expected 60", n_nib); else passes++;
    @(negedge sys_clk);
    checks++; if (eth_tx_en !== 1'b0 || eth_tx_data !== 4'h0) $display("FAIL rst_mid_tx_off: got en=%b data=%h expected 0/0", eth_tx_en, eth_tx_data); else passes++;
    checks++; if (busy !== 1'b0 || send_end !== 1'b0) $display("FAIL rst_mid_idle: got busy=%b end=%b expected 0/0", busy, send_end); else passes++;
    sys_rst_n = 1'b1;
    repeat (20) begin
      @(negedge sys_clk);
      if (send_end || eth_tx_en) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL rst_mid_no_send_end: got activity %b expected 0", seen); else passes++;
    run_frame(16'd8, 32'hC0FF_EE00, -1, 1'b0);
    build_expected(8, 16'h0000, 32'hC0FF_EE00);
    d = first_diff();
    checks++; if (field16(26) !== 16'h0000) $display("FAIL rst_mid_ident: got %h expected 0000", field16(26)); else passes++;
    checks++; if (d !== -1) $display("FAIL rst_mid_next_frame: first bad byte %0d expected none", d); else passes++;
  endtask

  initial begin
    test_reset();
    test_n4();
    test_n6();
    test_zero();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/udp_ip_send.md
UDP_IP_SEND -- requirements
Module: udp_ip_send

Interface
REQ-001 SHALL have parameter BOARD_MAC, default 48'h12_34_56_78_9A_BC, source MAC.
REQ-002 SHALL have parameter BOARD_IP, default {8'd169,8'd254,8'd1,8'd23}, source IP.
REQ-003 SHALL have parameter BOARD_PORT, default 16'd1234, UDP source port.
REQ-004 SHALL have parameters DES_MAC (48'hFF_FF_FF_FF_FF_FF), DES_IP ({8'd169,8'd254,8'd191,8'd31}) and DES_PORT (16'd1234), destination fields.
REQ-005 SHALL have port sys_clk, input, 1, single clock, rising edge; nibble rate.
REQ-006 SHALL have port sys_rst_n, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port send_en, input, 1, start pulse, sampled only in IDLE.
REQ-008 SHALL have port send_data_num, input, 16, payload byte count, sampled with send_en.
REQ-009 SHALL have port send_data, input, 32, payload word, valid the cycle after send_data_req.
REQ-010 SHALL have port send_data_req, output, 1, one-cycle word request.
REQ-011 SHALL have ports eth_tx_en (output, 1) and eth_tx_data (output, 4), PHY nibble stream.
REQ-012 SHALL have port send_end, output, 1, one-cycle frame-done pulse.
REQ-013 SHALL have port busy, output, 1, high from send_en acceptance to send_end inclusive.

Function
REQ-014 SHALL use FSM IDLE -> CHECK_SUM (3 cycles) -> PREAMBLE -> ETH_HEAD -> IP_UDP_HEAD -> SEND_DATA -> SEND_CRC -> IDLE.
REQ-015 SHALL drive the first preamble nibble on eth_tx_data exactly 4 cycles after the cycle send_en is sampled high.
REQ-016 SHALL emit every byte low nibble first; eth_tx_en high and eth_tx_data valid for every frame nibble, eth_tx_data=0 otherwise.
REQ-017 SHALL send preamble 55h x7 then SFD D5h (16 nibbles), not CRC-covered.
REQ-018 SHALL send ETH header: DES_MAC, BOARD_MAC, type 0800h, MSB byte first.
REQ-019 SHALL send IP header: 45h,00h, total length N+28, identification (16-bit counter, reset 0, +1 per sent frame, wraps), 4000h, TTL 40h, protocol 11h, header checksum, BOARD_IP, DES_IP.
REQ-020 SHALL compute the checksum in CHECK_SUM as the ones-complement of the end-around-carry sum of the ten header halfwords with the checksum field zero.
REQ-021 SHALL send UDP header: BOARD_PORT, DES_PORT, length N+8, checksum 0000h.
REQ-022 SHALL send payload bytes send_data[31:24] first; for N mod 4 != 0 the last word contributes only its upper N mod 4 bytes.
REQ-023 SHALL pulse send_data_req once per payload word, ceil(N/4) pulses total, the cycle before send_data is needed, none when N=0.
REQ-024 SHALL clamp send_data_num > 1472 to 1472.
REQ-025 SHALL append Ethernet CRC32 (poly 04C11DB7h, init FFFFFFFFh, reflected, final complement) over ETH header through last payload/pad byte, 8 nibbles.
REQ-026 SHALL drop eth_tx_en and pulse send_end in the cycle after the last CRC nibble.
REQ-027 SHALL ignore send_en while busy; send_en in the send_end cycle is ignored.

Reset
REQ-028 SHALL on sys_rst_n low at a clock edge force IDLE, eth_tx_en=0, eth_tx_data=0, send_data_req=0, send_end=0, busy=0, identification=0, CRC=FFFFFFFFh, including mid-frame (frame truncated, no send_end).

Configuration
REQ-029 SHALL, with macro UDP_TX_PAD_EN defined, append zero bytes after payload so IP+UDP+payload+pad >= 46 bytes (N<18), IP/UDP lengths unchanged.
REQ-030 SHALL, without UDP_TX_PAD_EN, emit no pad bytes.

Structure
REQ-031 SHALL place state enum, preamble/SFD, EtherType 0800h, TTL, protocol 11h, 1472 max-payload and CRC constants in shared package eth_pkg.
REQ-032 SHALL instantiate sub-module crc32_d4 (4-bit-per-cycle CRC with enable and clear).

Verification
REQ-033 SHALL check N=4, send_data=31323334h, pad on -> 144 nibbles, payload 31,32,33,34 then 14 zero bytes, IP length 0020h, UDP length 000Ch, CRC matches reference model.
REQ-034 SHALL check same stimulus pad off -> 116 nibbles, 1 send_data_req pulse.
REQ-035 SHALL check N=6 -> 2 req pulses, only bytes [31:16] of second word sent, IP length 0022h.
REQ-036 SHALL check two back-to-back frames -> identification 0000h then 0001h; send_en during first frame ignored.
REQ-037 SHALL check sys_rst_n low at nibble 60 -> eth_tx_en 0 next edge, no send_end, next frame identification 0000h.
REQ-038 SHALL check N=2000 -> clamped, IP length 05DCh, 368 req pulses.
